// File: rtl/icap_pkg.sv
// Shared types, ICAP command words and the per-byte bit-reversal helper
// used by the Spartan-6 IPROG sequencer.
package icap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] WORD_DUMMY   = 16'hFFFF;
  localparam logic [15:0] WORD_SYNC0   = 16'hAA99;
  localparam logic [15:0] WORD_SYNC1   = 16'h5566;
  localparam logic [15:0] HDR_GENERAL1 = 16'h3261;
  localparam logic [15:0] HDR_GENERAL2 = 16'h3281;
  localparam logic [15:0] HDR_GENERAL3 = 16'h32A1;
  localparam logic [15:0] HDR_GENERAL4 = 16'h32C1;
  localparam logic [15:0] HDR_GENERAL5 = 16'h32E1;
  localparam logic [15:0] HDR_CMD      = 16'h30A1;
  localparam logic [15:0] CMD_IPROG    = 16'h000E;
  localparam logic [15:0] WORD_NOOP    = 16'h2000;

  localparam logic [3:0] LAST_INDEX = 4'd15;

  // ICAP expects each byte with its bit order reversed relative to the
  // bitstream file; the byte order itself is unchanged.
  function automatic logic [15:0] bitswap16(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7 - i];
      r[8 + i] = w[15 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_word_mux.sv
// Maps a sequence index to the pre-swap IPROG command word, filling in the
// warm-boot address, golden fallback address and GENERAL5 tag.
module icap_word_mux
  import icap_pkg::*;
#(
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
  parameter logic [7:0]  SPI_OPCODE  = 8'h0B
) (
  input  logic [3:0]  index,
  input  logic [23:0] addr,
  input  logic [15:0] general5,
  output logic [15:0] word
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    word = WORD_DUMMY;
    case (index)
      4'd0:  word = WORD_DUMMY;
      4'd1:  word = WORD_SYNC0;
      4'd2:  word = WORD_SYNC1;
      4'd3:  word = HDR_GENERAL1;
      4'd4:  word = addr[15:0];
      4'd5:  word = HDR_GENERAL2;
      4'd6:  word = {SPI_OPCODE, addr[23:16]};
      4'd7:  word = HDR_GENERAL3;
      4'd8:  word = GOLDEN_ADDR[15:0];
      4'd9:  word = HDR_GENERAL4;
      4'd10: word = {SPI_OPCODE, GOLDEN_ADDR[23:16]};
      4'd11: word = HDR_GENERAL5;
      4'd12: word = general5;
      4'd13: word = HDR_CMD;
      4'd14: word = CMD_IPROG;
      4'd15: word = WORD_NOOP;
    endcase
  end

endmodule

// File: rtl/icap_iprog_sequencer.sv
// Accepts a design number and start pulse, computes the flash address of
// that bitstream and streams the IPROG command sequence into ICAP_SPARTAN6.
module icap_iprog_sequencer
  import icap_pkg::*;
#(
  parameter logic [23:0] SLOT_BYTES  = 24'h060000,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
  parameter logic [7:0]  SPI_OPCODE  = 8'h0B,
  parameter bit          BITSWAP     = 1'b1
) (
  input  logic        fastclk,
  input  logic        reset,
  input  logic [4:0]  design_num,
  input  logic        start,
  input  logic        icap_busy,
  output logic        busy,
  output logic        done,
  output logic        icap_ce_n,
  output logic        icap_write_n,
  output logic [15:0] icap_din
);

  state_t      state, state_next;
  logic [3:0]  index, index_next;
  logic [4:0]  cap_num;
  logic [23:0] addr;
  logic [15:0] general5;
  logic [15:0] word_raw;
  logic [15:0] word_out;

  logic        busy_next;
  logic        done_next;
  logic        ce_n_next;
  logic        write_n_next;
  logic [15:0] din_next;

  assign general5 = {11'd0, cap_num};

  icap_word_mux #(
    .GOLDEN_ADDR (GOLDEN_ADDR),
    .SPI_OPCODE  (SPI_OPCODE)
  ) u_word_mux (
    .index    (index),
    .addr     (addr),
    .general5 (general5),
    .word     (word_raw)
  );

  assign word_out = BITSWAP ? bitswap16(word_raw) : word_raw;

  always_comb begin
    state_next = state;
    index_next = index;
    busy_next  = busy;
    done_next  = 1'b0;
    ce_n_next  = 1'b1;
    din_next   = icap_din;

    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        state_next = SEND;
        index_next = '0;
        busy_next  = 1'b1;
      end
      SEND: begin
        // A stalled cycle keeps CE high and leaves index and data untouched,
        // so the same word is offered again once ICAP is ready.
        if (!icap_busy) begin
          ce_n_next  = 1'b0;
          din_next   = word_out;
          index_next = index + 4'd1;
          if (index == LAST_INDEX) state_next = DONE;
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // WRITE is asserted from start acceptance onward, ahead of the first CE.
    write_n_next = (state_next == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      icap_ce_n    <= 1'b1;
      icap_write_n <= 1'b1;
      icap_din     <= 16'hFFFF;
    end else begin
      state        <= state_next;
      index        <= index_next;
      busy         <= busy_next;
      done         <= done_next;
      icap_ce_n    <= ce_n_next;
      icap_write_n <= write_n_next;
      icap_din     <= din_next;
    end
  end

  // NOTE: these datapath registers are always loaded before they are read
  // (capture in IDLE, address in CALC), so they carry no reset.
  always_ff @(posedge fastclk) begin
    if (state == IDLE && start) cap_num <= design_num;
    if (state == CALC) begin
      addr <= cap_num[4] ? GOLDEN_ADDR : ({20'd0, cap_num[3:0]} * SLOT_BYTES);
    end
  end

endmodule

// File: tb/tb_icap_iprog_sequencer.sv
// Directed bench for icap_iprog_sequencer: table of design numbers plus
// hand-written stall, ignored-start and mid-sequence reset scenarios.
module tb_icap_iprog_sequencer;

  logic        fastclk;
  logic        reset;
  logic [4:0]  design_num;
  logic        start;
  logic        icap_busy;
  logic        busy;
  logic        done;
  logic        icap_ce_n;
  logic        icap_write_n;
  logic [15:0] icap_din;

  int n_checks;
  int n_fail;

  icap_iprog_sequencer dut (
    .fastclk      (fastclk),
    .reset        (reset),
    .design_num   (design_num),
    .start        (start),
    .icap_busy    (icap_busy),
    .busy         (busy),
    .done         (done),
    .icap_ce_n    (icap_ce_n),
    .icap_write_n (icap_write_n),
    .icap_din     (icap_din)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  typedef struct {
    logic [4:0]  dn;
    logic [15:0] w4;
    logic [15:0] w6;
    logic [15:0] w12;
  } vec_t;

  vec_t vecs [7];

  // Expected ICAP data after per-byte bit reversal.
  function automatic logic [15:0] swapped(input logic [15:0] w);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = {<<{w[15:8]}};
    lo = {<<{w[7:0]}};
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge fastclk);
    @(negedge fastclk);
  endtask

  // Runs one start/sequence. stall_after: word index after which ICAP stalls
  // 3 cycles; inject_at: word index before which a stray start is pulsed;
  // abort_after: return once this many words have been observed.
  task automatic run_seq(input logic [4:0] dn, input logic [15:0] w4,
                         input logic [15:0] w6, input logic [15:0] w12,
                         input int stall_after, input int inject_at,
                         input int abort_after);
    logic [15:0] exp [16];
    logic [15:0] hdr [3];
    exp = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, w4, 16'h3281, w6,
            16'h32A1, 16'h0000, 16'h32C1, 16'h0B00, 16'h32E1, w12,
            16'h30A1, 16'h000E, 16'h2000};
    hdr = '{16'hFFFF, 16'h5599, 16'hAA66};

    design_num = dn;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    design_num = ~dn;
    check("write_n_calc", 16'(icap_write_n), 16'd0);
    check("ce_n_calc", 16'(icap_ce_n), 16'd1);
    tick();
    check("busy_rise", 16'(busy), 16'd1);
    check("ce_n_prefirst", 16'(icap_ce_n), 16'd1);

    for (int k = 0; k < 16; k++) begin
      if (k == abort_after) return;
      if (k == inject_at) begin
        start      = 1'b1;
        design_num = 5'd9;
      end
      tick();
      start = 1'b0;
      check($sformatf("ce_n_w%0d", k), 16'(icap_ce_n), 16'd0);
      check($sformatf("din_w%0d", k), icap_din, swapped(exp[k]));
      check($sformatf("busy_w%0d", k), 16'(busy), 16'd1);
      check($sformatf("done_w%0d", k), 16'(done), 16'd0);
      if (k < 3) check($sformatf("raw_hdr_w%0d", k), icap_din, hdr[k]);
      if (k == stall_after) begin
        icap_busy = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          check($sformatf("stall_ce_n_%0d", s), 16'(icap_ce_n), 16'd1);
          check($sformatf("stall_din_%0d", s), icap_din, swapped(exp[k]));
        end
        icap_busy = 1'b0;
      end
    end

    tick();
    check("done_pulse", 16'(done), 16'd1);
    check("busy_in_done", 16'(busy), 16'd0);
    check("ce_n_done", 16'(icap_ce_n), 16'd1);
    tick();
    check("done_clear", 16'(done), 16'd0);
    check("write_n_idle", 16'(icap_write_n), 16'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    design_num = 5'd0;
    icap_busy  = 1'b0;

    // Slot n sits at n*0x060000, so addr[15:0] is always zero here.
    vecs[0] = '{5'd3,  16'h0000, 16'h0B12, 16'h0003};
    vecs[1] = '{5'd16, 16'h0000, 16'h0B00, 16'h0010};
    vecs[2] = '{5'd0,  16'h0000, 16'h0B00, 16'h0000};
    vecs[3] = '{5'd1,  16'h0000, 16'h0B06, 16'h0001};
    vecs[4] = '{5'd15, 16'h0000, 16'h0B5A, 16'h000F};
    vecs[5] = '{5'd31, 16'h0000, 16'h0B00, 16'h001F};
    vecs[6] = '{5'd10, 16'h0000, 16'h0B3C, 16'h000A};

    repeat (2) @(negedge fastclk);
    tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_ce_n", 16'(icap_ce_n), 16'd1);
    check("rst_write_n", 16'(icap_write_n), 16'd1);
    check("rst_din", icap_din, 16'hFFFF);
    reset = 1'b0;
    tick();
    check("idle_ce_n", 16'(icap_ce_n), 16'd1);

    for (int v = 0; v < 7; v++) begin
      run_seq(vecs[v].dn, vecs[v].w4, vecs[v].w6, vecs[v].w12, -1, -1, 16);
    end

    // ICAP stall after word 7 (32A1) has been written.
    run_seq(5'd3, 16'h0000, 16'h0B12, 16'h0003, 7, -1, 16);

    // Stray start at index 4 with design 9 must be ignored.
    run_seq(5'd3, 16'h0000, 16'h0B12, 16'h0003, -1, 4, 16);

    // Reset with word 8 pending, then a clean replay.
    run_seq(5'd3, 16'h0000, 16'h0B12, 16'h0003, -1, -1, 8);
    reset = 1'b1;
    tick();
    check("midrst_ce_n", 16'(icap_ce_n), 16'd1);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_din", icap_din, 16'hFFFF);
    check("midrst_write_n", 16'(icap_write_n), 16'd1);
    check("midrst_done", 16'(done), 16'd0);
    reset = 1'b0;
    tick();
    check("postrst_ce_n", 16'(icap_ce_n), 16'd1);
    run_seq(5'd16, 16'h0000, 16'h0B00, 16'h0010, -1, -1, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
